// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C EEPROM slave: FSM state encoding and the
// legal parameter ranges used to reject bad configurations at elaboration.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CTRL      = 4'd1,
        CTRL_ACK  = 4'd2,
        WADDR     = 4'd3,
        WADDR_ACK = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    localparam int ADDR_W_MIN = 8;
    localparam int ADDR_W_MAX = 11;
    localparam int PAGE_W_MIN = 0;
    localparam int FILT_MIN   = 1;
    localparam int FILT_MAX   = 7;

    function automatic bit params_legal(input int addr_w, input int page_w, input int filt);
        return (addr_w >= ADDR_W_MIN) && (addr_w <= ADDR_W_MAX) &&
               (page_w >= PAGE_W_MIN) && (page_w <= addr_w) &&
               (filt >= FILT_MIN) && (filt <= FILT_MAX);
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus FILT-cycle stability filter for SCL and SDA,
// producing filtered SDA and registered SCL-edge / START / STOP strobes.
module i2c_line_filter #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    // index 0 carries SCL, index 1 carries SDA
    logic [1:0] meta_r;
    logic [1:0] sync_r;
    logic [1:0] filt_r;
    logic [2:0] cnt_r [2];
    logic [1:0] nxt_s;
    logic       scl_rise_r;
    logic       scl_fall_r;
    logic       start_r;
    logic       stop_r;

    // A line only flips once the synchronised value has disagreed for FILT samples.
    always_comb begin
        nxt_s = filt_r;
        for (int i = 0; i < 2; i++) begin
            if ((sync_r[i] != filt_r[i]) && (cnt_r[i] == 3'(FILT - 1))) begin
                nxt_s[i] = sync_r[i];
            end else begin
                nxt_s[i] = filt_r[i];
            end
        end
    end

    // Synchroniser, filter counters and edge/condition strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r     <= 2'b11;
            sync_r     <= 2'b11;
            filt_r     <= 2'b11;
            cnt_r[0]   <= 3'd0;
            cnt_r[1]   <= 3'd0;
            scl_rise_r <= 1'b0;
            scl_fall_r <= 1'b0;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
        end else begin
            meta_r <= {sda_i, scl_i};
            sync_r <= meta_r;
            filt_r <= nxt_s;
            for (int i = 0; i < 2; i++) begin
                if ((sync_r[i] == filt_r[i]) || (nxt_s[i] != filt_r[i])) begin
                    cnt_r[i] <= 3'd0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + 3'd1;
                end
            end
            scl_rise_r <= nxt_s[0] & ~filt_r[0];
            scl_fall_r <= ~nxt_s[0] & filt_r[0];
            start_r    <= filt_r[0] & nxt_s[0] & filt_r[1] & ~nxt_s[1];
            stop_r     <= filt_r[0] & nxt_s[0] & ~filt_r[1] & nxt_s[1];
        end
    end

    assign sda      = filt_r[1];
    assign scl_rise = scl_rise_r;
    assign scl_fall = scl_fall_r;
    assign start    = start_r;
    assign stop     = stop_r;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// 24Cxx-style I2C EEPROM slave: byte/page writes, current-address, random and
// sequential reads out of an internal 2^ADDR_W x 8 single-port RAM.
module i2c_eeprom_slave
    import i2c_pkg::*;
#(
    parameter logic [3:0] DEV_ID = 4'b1010,
    parameter int         ADDR_W = 11,
    parameter int         PAGE_W = 4,
    parameter int         FILT   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              busy,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr
);

    if (!params_legal(ADDR_W, PAGE_W, FILT)) begin : g_param_check
        $error("i2c_eeprom_slave: illegal ADDR_W/PAGE_W/FILT combination");
    end

    logic              sda_f_s;
    logic              scl_rise_s;
    logic              scl_fall_s;
    logic              start_s;
    logic              stop_s;

    state_t            state_r;
    logic [3:0]        bit_cnt_r;
    logic [7:0]        shift_r;
    logic [6:0]        tx_r;
    logic [3:0]        ctrl_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [7:0]        rd_data_r;
    logic              sda_oe_r;
    logic              busy_r;
    logic              wr_pulse_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic              we_s;
    logic [10:0]       addr_full_s;

    logic [7:0]        mem_r [2**ADDR_W];

    // Page-mode increment: low PAGE_W bits roll over, the page number is kept.
    function automatic logic [ADDR_W-1:0] page_inc(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] mask;
        logic [ADDR_W-1:0] nxt;
        mask = ADDR_W'((32'd1 << PAGE_W) - 32'd1);
        nxt  = a + {{(ADDR_W-1){1'b0}}, 1'b1};
        return (a & ~mask) | (nxt & mask);
    endfunction

    i2c_line_filter #(
        .FILT(FILT)
    ) u_filt (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda      (sda_f_s),
        .scl_rise (scl_rise_s),
        .scl_fall (scl_fall_s),
        .start    (start_s),
        .stop     (stop_s)
    );

    assign addr_full_s = {ctrl_r[3:1], shift_r};

    // A data byte is committed only on the SCL fall that follows its 8th bit.
    always_comb begin
        if (scl_fall_s && !start_s && !stop_s && (state_r == WDATA) && (bit_cnt_r == 4'd8)) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end

    // Single-port RAM; the read port tracks the pointer with one clk latency.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[ptr_r] <= shift_r;
        end
        rd_data_r <= mem_r[ptr_r];
    end

    // Protocol FSM; SDA is only ever changed on the clk after an SCL fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'd0;
            tx_r       <= 7'd0;
            ctrl_r     <= 4'd0;
            ptr_r      <= '0;
            sda_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
            wr_pulse_r <= 1'b0;
            wr_addr_r  <= '0;
        end else begin
            wr_pulse_r <= 1'b0;
            if (stop_s) begin
                state_r   <= IDLE;
                bit_cnt_r <= 4'd0;
                sda_oe_r  <= 1'b0;
                busy_r    <= 1'b0;
            end else if (start_s) begin
                state_r   <= CTRL;
                bit_cnt_r <= 4'd0;
            end else begin
                if (scl_rise_s) begin
                    shift_r   <= {shift_r[6:0], sda_f_s};
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                end
                if (scl_fall_s) begin
                    case (state_r)
                        CTRL: begin
                            if (bit_cnt_r == 4'd8) begin
                                if (shift_r[7:4] == DEV_ID) begin
                                    ctrl_r   <= shift_r[3:0];
                                    busy_r   <= 1'b1;
                                    sda_oe_r <= 1'b1;
                                    state_r  <= CTRL_ACK;
                                end else begin
                                    busy_r   <= 1'b0;
                                    sda_oe_r <= 1'b0;
                                    state_r  <= WAIT_STOP;
                                end
                            end
                        end
                        CTRL_ACK: begin
                            bit_cnt_r <= 4'd0;
                            if (ctrl_r[0]) begin
                                tx_r     <= rd_data_r[6:0];
                                sda_oe_r <= ~rd_data_r[7];
                                state_r  <= RDATA;
                            end else begin
                                sda_oe_r <= 1'b0;
                                state_r  <= WADDR;
                            end
                        end
                        WADDR: begin
                            if (bit_cnt_r == 4'd8) begin
                                ptr_r    <= addr_full_s[ADDR_W-1:0];
                                sda_oe_r <= 1'b1;
                                state_r  <= WADDR_ACK;
                            end
                        end
                        WADDR_ACK, WDATA_ACK: begin
                            bit_cnt_r <= 4'd0;
                            sda_oe_r  <= 1'b0;
                            state_r   <= WDATA;
                        end
                        WDATA: begin
                            if (bit_cnt_r == 4'd8) begin
                                wr_pulse_r <= 1'b1;
                                wr_addr_r  <= ptr_r;
                                ptr_r      <= page_inc(ptr_r);
                                sda_oe_r   <= 1'b1;
                                state_r    <= WDATA_ACK;
                            end
                        end
                        RDATA: begin
                            if (bit_cnt_r == 4'd8) begin
                                sda_oe_r <= 1'b0;
                                ptr_r    <= ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                                state_r  <= RDATA_ACK;
                            end else begin
                                sda_oe_r <= ~tx_r[6];
                                tx_r     <= {tx_r[5:0], 1'b0};
                            end
                        end
                        RDATA_ACK: begin
                            // shift_r[0] holds SDA as sampled on the 9th SCL rise
                            if (!shift_r[0]) begin
                                bit_cnt_r <= 4'd0;
                                tx_r      <= rd_data_r[6:0];
                                sda_oe_r  <= ~rd_data_r[7];
                                state_r   <= RDATA;
                            end else begin
                                busy_r  <= 1'b0;
                                state_r <= WAIT_STOP;
                            end
                        end
                        default: begin
                            sda_oe_r <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign sda_oe   = sda_oe_r;
    assign busy     = busy_r;
    assign wr_pulse = wr_pulse_r;
    assign wr_addr  = wr_addr_r;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: bit-banged I2C master, directed scenarios plus
// random transactions checked against an array model of the EEPROM.
module tb_i2c_eeprom_slave;
    import i2c_pkg::*;

    localparam int AW = 11;
    localparam int Q  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scl_m = 1'b1;
    logic          sda_m = 1'b1;
    logic          sda_oe;
    logic          busy;
    logic          wr_pulse;
    logic [AW-1:0] wr_addr;
    wire           sda_line = sda_m & ~sda_oe;

    int            total = 0;
    int            bad = 0;
    int            wr_n = 0;
    int            oe_cnt = 0;
    logic [AW-1:0] wr_log [256];

    logic [7:0]    mem_m [2048];
    bit            valid_m [2048];
    int            ptr_m = 0;
    logic [7:0]    wbuf [16];

    always #5 clk = ~clk;

    i2c_eeprom_slave #(
        .DEV_ID (4'b1010),
        .ADDR_W (AW),
        .PAGE_W (4),
        .FILT   (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_m),
        .sda_i    (sda_line),
        .sda_oe   (sda_oe),
        .busy     (busy),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr)
    );

    // Log every committed byte address and count cycles SDA is pulled low.
    always @(posedge clk) begin
        if (wr_pulse) begin
            wr_log[wr_n % 256] <= wr_addr;
            wr_n <= wr_n + 1;
        end
        if (sda_oe) begin
            oe_cnt <= oe_cnt + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic put_byte(input logic [7:0] b, output bit ack);
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        ack = (sda_line == 1'b0);
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic get_byte(input bit ack, output logic [7:0] d);
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1; wait_q();
            scl_m = 1'b1; wait_q();
            d = {d[6:0], sda_line};
            wait_q();
            scl_m = 1'b0; wait_q();
        end
        sda_m = ack ? 1'b0 : 1'b1; wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
        sda_m = 1'b1;
    endtask

    // Byte/page write of wbuf[0..n-1] starting at addr.
    task automatic xact_write(input logic [10:0] addr, input int n);
        bit            a;
        int            base;
        int            p;
        logic [AW-1:0] exp_addr [16];
        base = wr_n;
        bus_start();
        put_byte({4'hA, addr[10:8], 1'b0}, a);
        check_eq("w_ctrl_ack", a, 1);
        check_eq("w_busy", busy, 1);
        put_byte(addr[7:0], a);
        check_eq("w_addr_ack", a, 1);
        p = addr;
        for (int i = 0; i < n; i++) begin
            put_byte(wbuf[i], a);
            check_eq("w_data_ack", a, 1);
            mem_m[p]    = wbuf[i];
            valid_m[p]  = 1'b1;
            exp_addr[i] = AW'(p);
            p = (p / 16) * 16 + ((p % 16) + 1) % 16;
        end
        bus_stop();
        ptr_m = p;
        check_eq("w_pulses", wr_n - base, n);
        for (int i = 0; i < n; i++) check_eq("w_wr_addr", wr_log[(base + i) % 256], exp_addr[i]);
        check_eq("w_busy_end", busy, 0);
    endtask

    // Random read (with_addr) or current-address read of n bytes, last NACKed.
    task automatic xact_read(input bit with_addr, input logic [10:0] addr, input int n);
        bit         a;
        logic [7:0] d;
        logic [2:0] hi;
        if (with_addr) begin
            bus_start();
            put_byte({4'hA, addr[10:8], 1'b0}, a);
            check_eq("r_ctrlw_ack", a, 1);
            put_byte(addr[7:0], a);
            check_eq("r_addr_ack", a, 1);
            ptr_m = addr;
        end
        hi = 3'($urandom);
        bus_start();
        put_byte({4'hA, hi, 1'b1}, a);
        check_eq("r_ctrl_ack", a, 1);
        for (int i = 0; i < n; i++) begin
            get_byte(i < n - 1, d);
            if (valid_m[ptr_m]) check_eq("r_data", d, mem_m[ptr_m]);
            ptr_m = (ptr_m + 1) % 2048;
        end
        check_eq("r_nack_busy", busy, 0);
        bus_stop();
        check_eq("r_sda_rel", sda_oe, 0);
        check_eq("r_busy_end", busy, 0);
    endtask

    initial begin
        bit            a;
        int            base_wr;
        int            base_oe;
        int            waited;
        int            kind;
        logic [10:0]   last_base;
        logic [10:0]   ra;

        repeat (5) @(negedge clk);
        check_eq("rst_sda_oe", sda_oe, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_wr_pulse", wr_pulse, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Byte write 0x5A at 0x210 then random read back.
        wbuf[0] = 8'h5A;
        xact_write(11'h210, 1);
        check_eq("s1_wr_addr", wr_addr, 11'h210);
        xact_read(1'b1, 11'h210, 1);

        // Page write crossing the 16-byte page boundary.
        for (int i = 0; i < 4; i++) wbuf[i] = 8'(i + 1);
        xact_write(11'h00E, 4);
        xact_read(1'b1, 11'h00E, 2);
        xact_read(1'b1, 11'h000, 2);

        // Sequential read wrapping from the top of memory.
        wbuf[0] = 8'h77;
        xact_write(11'h7FF, 1);
        xact_read(1'b1, 11'h7FF, 3);

        // Wrong device id: no ACK, no write, SDA never pulled.
        base_wr = wr_n;
        base_oe = oe_cnt;
        bus_start();
        put_byte(8'hB0, a);
        check_eq("id_nack", a, 0);
        check_eq("id_busy", busy, 0);
        put_byte(8'h33, a);
        check_eq("id_nack2", a, 0);
        bus_stop();
        check_eq("id_no_oe", oe_cnt - base_oe, 0);
        check_eq("id_no_wr", wr_n - base_wr, 0);

        // STOP after 5 bits of a data byte discards it.
        base_wr = wr_n;
        bus_start();
        put_byte(8'hA0, a);
        check_eq("p5_ctrl_ack", a, 1);
        put_byte(8'h40, a);
        check_eq("p5_addr_ack", a, 1);
        ptr_m = 11'h040;
        for (int i = 0; i < 5; i++) put_bit(1'($urandom));
        bus_stop();
        check_eq("p5_no_wr", wr_n - base_wr, 0);
        check_eq("p5_idle", dut.state_r, IDLE);
        check_eq("p5_busy", busy, 0);

        // Reset while the slave is ACKing the control byte.
        bus_start();
        for (int i = 7; i >= 0; i--) put_bit(i == 7 || i == 5);
        sda_m = 1'b1;
        waited = 0;
        while (sda_oe !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_eq("rst_ack_seen", sda_oe, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_sda_rel", sda_oe, 0);
        check_eq("rst_busy_mid", busy, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        ptr_m = 0;
        xact_read(1'b0, 11'd0, 1);
        xact_read(1'b1, 11'h210, 1);

        // One-clk SDA glitch on an idle bus must not look like a START.
        @(negedge clk);
        sda_m = 1'b0;
        @(negedge clk);
        sda_m = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("glitch_idle", dut.state_r, IDLE);
        check_eq("glitch_busy", busy, 0);

        // Random traffic against the model.
        last_base = 11'h210;
        for (int it = 0; it < 8; it++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                ra = 11'($urandom_range(0, 2047));
                kind = $urandom_range(1, 5);
                for (int j = 0; j < kind; j++) wbuf[j] = 8'($urandom);
                xact_write(ra, kind);
                last_base = ra;
            end else if (kind == 1) begin
                xact_read(1'b1, last_base, $urandom_range(1, 4));
            end else begin
                xact_read(1'b0, 11'd0, $urandom_range(1, 3));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
